// File: rtl/mbtrain_repair_rx_gen_if.sv
// Sideband channel bundle between the MBTRAIN REPAIR receive-side responder and the
// sideband transmit path (incoming decoded messages, serializer status, outgoing response).
interface mbtrain_repair_rx_gen_if #(
  parameter int NUM_GROUPS = 2
);
  logic [3:0]            i_sideband_message;
  logic [NUM_GROUPS-1:0] i_sideband_lane_mask;
  logic                  i_busy_negedge_detected;
  logic                  i_valid_tx;
  logic [3:0]            o_sideband_message;
  logic                  o_valid_rx;

  // Responder side: consumes requests and channel status, produces the response.
  modport slave (
    input  i_sideband_message,
    input  i_sideband_lane_mask,
    input  i_busy_negedge_detected,
    input  i_valid_tx,
    output o_sideband_message,
    output o_valid_rx
  );

  // Sideband side: delivers requests and channel status, consumes the response.
  modport master (
    output i_sideband_message,
    output i_sideband_lane_mask,
    output i_busy_negedge_detected,
    output i_valid_tx,
    input  o_sideband_message,
    input  o_valid_rx
  );
endinterface

// File: rtl/mbtrain_repair_rx_gen.sv
// mbtrain_repair_rx_gen: receive-side responder for the MBTRAIN REPAIR substep.
// Answers the partner's INIT / APPLY_DEGRADE / END requests over a sideband channel
// shared with the TX-side repair block, captures the partner's per-group lane mask,
// and aborts with a timeout flag if the partner stalls in any wait/send state.
module mbtrain_repair_rx_gen #(
  parameter int NUM_GROUPS     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  mbtrain_repair_rx_gen_if.slave sb,
  output logic                  o_test_ack,
  output logic                  o_timeout,
  output logic [NUM_GROUPS-1:0] o_remote_group_ok,
  output logic                  o_no_lanes
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] INIT_REQ = 4'b0001;
  localparam logic [3:0] INIT_RSP = 4'b0010;
  localparam logic [3:0] END_REQ  = 4'b0101;
  localparam logic [3:0] END_RSP  = 4'b0110;
  localparam logic [3:0] DEG_REQ  = 4'b0111;
  localparam logic [3:0] DEG_RSP  = 4'b1000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    WAIT_DEG,
    WAIT_END,
    SEND_END,
    DONE,
    TIMEOUT_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [3:0]            msg_q, msg_d;
  logic                  valid_q, valid_d;
  logic                  validPrev_q;
  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_GROUPS-1:0] mask_q, mask_d;
  logic                  noLanes_q, noLanes_d;

  logic chanIdle;
  logic timerExpired;
  logic timedState;
  logic [3:0] rxMsg;

  // A new request is only looked at once the previous response has fully left the channel.
  assign chanIdle     = !pending_q && !valid_q;
  assign timerExpired = (timer_q == TIMER_MAX);
  assign timedState   = (state_q inside {WAIT_INIT, WAIT_DEG, WAIT_END, SEND_END});
  assign rxMsg        = sb.i_sideband_message;

  // Next-state, response queueing, handshake and timer; later sections override earlier ones.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    msg_d     = msg_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    ack_d     = ack_q;
    timeout_d = timeout_q;
    mask_d    = mask_q;
    noLanes_d = noLanes_q;

    unique case (state_q)
      IDLE: begin
        state_d   = WAIT_INIT;
        mask_d    = '0;
        noLanes_d = 1'b0;
      end
      WAIT_INIT: begin
        if (chanIdle && rxMsg == INIT_REQ) begin
          state_d   = WAIT_DEG;
          msg_d     = INIT_RSP;
          pending_d = 1'b1;
        end else if (timerExpired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      WAIT_DEG: begin
        if (chanIdle && rxMsg == DEG_REQ) begin
          state_d   = WAIT_END;
          msg_d     = DEG_RSP;
          pending_d = 1'b1;
          mask_d    = sb.i_sideband_lane_mask;
          noLanes_d = (sb.i_sideband_lane_mask == '0);
        end else if (timerExpired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      WAIT_END: begin
        if (chanIdle && rxMsg == DEG_REQ) begin
          msg_d     = DEG_RSP;
          pending_d = 1'b1;
          mask_d    = sb.i_sideband_lane_mask;
          noLanes_d = (sb.i_sideband_lane_mask == '0);
        end else if (chanIdle && rxMsg == END_REQ) begin
          state_d   = SEND_END;
          msg_d     = END_RSP;
          pending_d = 1'b1;
        end else if (timerExpired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      SEND_END: begin
        if (!valid_q && validPrev_q) begin
          state_d = DONE;
          ack_d   = 1'b1;
          msg_d   = '0;
        end else if (timerExpired) begin
          state_d = TIMEOUT_ERR;
        end
      end
      DONE: begin
        ack_d = 1'b1;
      end
      TIMEOUT_ERR: begin
        state_d = TIMEOUT_ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A busy negedge ends the current message and also drops anything queued this cycle.
    if (sb.i_busy_negedge_detected) begin
      valid_d   = 1'b0;
      pending_d = 1'b0;
    end else if (pending_q && !sb.i_valid_tx) begin
      valid_d = 1'b1;
    end

    if (state_d == TIMEOUT_ERR) begin
      timeout_d = 1'b1;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      ack_d     = 1'b0;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timedState) begin
      timer_d = timer_q + TW'(1);
    end

    // Losing the substep enable abandons everything except the last captured mask.
    if (!i_en) begin
      state_d   = IDLE;
      timer_d   = '0;
      msg_d     = '0;
      valid_d   = 1'b0;
      pending_d = 1'b0;
      ack_d     = 1'b0;
      timeout_d = 1'b0;
      mask_d    = mask_q;
      noLanes_d = noLanes_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      msg_q       <= '0;
      valid_q     <= 1'b0;
      validPrev_q <= 1'b0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      timeout_q   <= 1'b0;
      mask_q      <= '0;
      noLanes_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      msg_q       <= msg_d;
      valid_q     <= valid_d;
      validPrev_q <= valid_q;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      timeout_q   <= timeout_d;
      mask_q      <= mask_d;
      noLanes_q   <= noLanes_d;
    end
  end

  assign sb.o_sideband_message = msg_q;
  assign sb.o_valid_rx         = valid_q;
  assign o_test_ack            = ack_q;
  assign o_timeout             = timeout_q;
  assign o_remote_group_ok     = mask_q;
  assign o_no_lanes            = noLanes_q;

endmodule
